// File: rtl/tlu_word_packer.sv
// tlu_word_packer
//   Pops 16-bit words from the TLU readout FIFO, pairs them into 32-bit words
//   and buffers them in a small first-word-fall-through output FIFO. One
//   trigger record is 8 x 16-bit words, which gives 4 x 32-bit words:
//     pair 0 = LE, pair 1 = TIME_STAMP[31:0], pair 2 = TIME_STAMP[63:32],
//     pair 3 = TRIG_ID. Pair 0 is flagged with OUT_SOF and pair 3 with OUT_EOF.
//
// Ports
//   BUS_CLK, RST         clock, synchronous active-high reset
//   IN_DATA, IN_EMPTY    upstream word / upstream has no word
//   IN_READ              pop strobe, word consumed on the edge where it is 1
//   OUT_DATA/SOF/EOF     head of the output FIFO (zero while empty)
//   OUT_VALID/OUT_READY  output handshake, transfer when both are 1
//   RECORD_CNT           records written to the output FIFO, wraps
//   STALL_ERR            sticky: a partial record waited too long upstream
//   ID_ERR_CNT           saturating count of trigger-ID discontinuities
//
// Build option
//   TLU_PACKER_ID_CHECK_EN  when defined, every TRIG_ID is compared against
//                           the previous one + 1; otherwise ID_ERR_CNT is 0.
//
// States
//   LOW  | waiting for the low half of a pair (stored into lo_reg)
//   HIGH | waiting for the high half; its pop writes the pair to the FIFO

module tlu_word_packer #(
  parameter int DEPTH         = 16,
  parameter int STALL_TIMEOUT = 255
) (
  input  logic        BUS_CLK,
  input  logic        RST,
  input  logic [15:0] IN_DATA,
  input  logic        IN_EMPTY,
  output logic        IN_READ,
  output logic [31:0] OUT_DATA,
  output logic        OUT_SOF,
  output logic        OUT_EOF,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [15:0] RECORD_CNT,
  output logic        STALL_ERR,
  output logic [7:0]  ID_ERR_CNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(STALL_TIMEOUT + 1);

  typedef enum logic {LOW, HIGH} state_t;

  state_t         state, state_nxt;
  logic [2:0]     widx;
  logic [15:0]    lo_reg;
  logic [33:0]    mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  logic           fifo_full, fifo_empty;
  logic           pop, wr_en, xfer, eof_wr;
  logic [33:0]    wr_entry, head;
  logic [TW-1:0]  stall_tmr;

  // Fullness comes from the registered count only, so a slot freed by a
  // transfer becomes poppable one cycle later and OUT_READY never reaches
  // IN_READ combinationally.
  assign fifo_full  = (count == (AW + 1)'(DEPTH));
  assign fifo_empty = (count == '0);
  assign IN_READ    = !IN_EMPTY && !fifo_full;
  assign pop        = IN_READ;
  assign xfer       = !fifo_empty && OUT_READY;

  // Entry layout: {EOF, SOF, high word, low word}
  assign wr_entry = {(widx == 3'd7), (widx == 3'd1), IN_DATA, lo_reg};
  assign eof_wr   = wr_en && (widx == 3'd7);

  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      state  <= LOW;
      widx   <= '0;
      lo_reg <= '0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        widx <= widx + 3'd1;
        if (state == LOW) lo_reg <= IN_DATA;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    case (state)
      LOW: begin
        if (pop) state_nxt = HIGH;
      end
      HIGH: begin
        if (pop) begin
          wr_en     = 1'b1;
          state_nxt = LOW;
        end
      end
      default: state_nxt = LOW;
    endcase
  end

  // Output FIFO storage; no reset needed, validity is tracked by count.
  always_ff @(posedge BUS_CLK) begin
    if (wr_en && !RST) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (xfer)  rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, xfer})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head      = mem[rd_ptr];
  assign OUT_VALID = !fifo_empty;
  assign OUT_DATA  = fifo_empty ? 32'h0 : head[31:0];
  assign OUT_SOF   = !fifo_empty && head[32];
  assign OUT_EOF   = !fifo_empty && head[33];

  always_ff @(posedge BUS_CLK) begin
    if (RST) RECORD_CNT <= '0;
    else if (eof_wr) RECORD_CNT <= RECORD_CNT + 16'd1;
  end

  // Stall timer: down-counter reloaded on every pop and while no record is
  // in progress. It only counts while upstream is empty; a full FIFO is
  // backpressure, not a stall. Terminal count sets the sticky flag.
  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      stall_tmr <= TW'(STALL_TIMEOUT);
      STALL_ERR <= 1'b0;
    end else if (pop || widx == 3'd0) begin
      stall_tmr <= TW'(STALL_TIMEOUT);
    end else if (IN_EMPTY && !fifo_full && stall_tmr != '0) begin
      stall_tmr <= stall_tmr - 1'b1;
      if (stall_tmr == TW'(1)) STALL_ERR <= 1'b1;
    end
  end

`ifdef TLU_PACKER_ID_CHECK_EN
  logic [31:0] prev_id;
  logic        id_seen;
  logic [7:0]  id_err;
  logic [31:0] cur_id;

  assign cur_id = {IN_DATA, lo_reg};

  // The first record after reset only seeds prev_id.
  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      prev_id <= '0;
      id_seen <= 1'b0;
      id_err  <= '0;
    end else if (eof_wr) begin
      prev_id <= cur_id;
      id_seen <= 1'b1;
      if (id_seen && cur_id != prev_id + 32'd1 && id_err != 8'hFF)
        id_err <= id_err + 8'd1;
    end
  end

  assign ID_ERR_CNT = id_err;
`else
  assign ID_ERR_CNT = 8'h00;
`endif

endmodule

// File: doc/tlu_word_packer.md
Name: tlu_word_packer

Overview:
- Sits directly downstream of the TLU master core's 16-bit readout FIFO port, in the BUS_CLK domain.
- Pops 16-bit words, pairs them into 32-bit words and buffers them in a small output FIFO.
- Marks record boundaries: one trigger record is 8 x 16-bit words, giving 4 x 32-bit words with SOF/EOF sidebands.
- Feeds the readout arbiter through a valid/ready handshake.
- Reports record count and incomplete-record errors.

Parameters:
- DEPTH, 16, output FIFO depth in 32-bit entries; power of 2, minimum 4.
- STALL_TIMEOUT, 255, BUS_CLK cycles a partially received record may wait for its next word before STALL_ERR is set.

Ports:
- BUS_CLK  input  1  clock
- RST  input  1  reset
- IN_DATA  input  16  upstream word; valid while IN_EMPTY=0
- IN_EMPTY  input  1  upstream has no word
- IN_READ  output  1  pop strobe; word consumed at the edge where IN_READ=1
- OUT_DATA  output  32  packed word
- OUT_SOF  output  1  OUT_DATA is pair 0 of a record
- OUT_EOF  output  1  OUT_DATA is pair 3 of a record
- OUT_VALID  output  1  OUT_DATA/SOF/EOF valid
- OUT_READY  input  1  consumer accepts
- RECORD_CNT  output  16  records written to the output FIFO, wraps
- STALL_ERR  output  1  sticky incomplete-record flag
- ID_ERR_CNT  output  8  trigger-ID discontinuities (see Optional Feature)

Behaviour:
- Reset is RST, synchronous, active-high, clock BUS_CLK.
- Reset values:
  - IN_READ=0, OUT_VALID=0, OUT_SOF=0, OUT_EOF=0, OUT_DATA=0.
  - RECORD_CNT=0, STALL_ERR=0, ID_ERR_CNT=0.
  - Word index WIDX=0, FIFO empty.
- Reset mid-record discards the partial pair and all buffered words. Upstream is reset by the same RST.
- Pop rule:
  - IN_READ = !IN_EMPTY & !fifo_full. Combinational from registered state only; no path from OUT_READY.
  - A slot freed by an output transfer at edge N is usable from cycle N+1.
- WIDX (3 bits) increments on every pop and wraps 7->0.
- FSM states:
  - LOW: pop stores IN_DATA into lo_reg, go to HIGH.
  - HIGH: pop writes {IN_DATA, lo_reg} to the FIFO with SOF=(WIDX==1) and EOF=(WIDX==7), go to LOW.
- Record layout:
  - Pair 0 = LE[1:0]; pairs 1-2 = TIME_STAMP[31:0] then TIME_STAMP[63:32]; pair 3 = TRIG_ID[31:0].
  - Word 0 is the first word popped after reset.
- RECORD_CNT increments on each EOF write and wraps 0xFFFF->0.
- Output FIFO:
  - Registered memory with 34-bit entries (data, SOF, EOF), first-word-fall-through.
  - A word written at edge N drives OUT_VALID=1 from cycle N+1 when the FIFO was empty.
  - A transfer occurs when OUT_VALID & OUT_READY. OUT_DATA holds stable while OUT_VALID=1 and OUT_READY=0.
  - Simultaneous write and transfer keeps the occupancy unchanged.
  - Full = DEPTH entries: no write and IN_READ=0.
  - Empty: OUT_VALID=0.
- Stall detection:
  - Counter runs while WIDX!=0 and IN_EMPTY=1; it clears on any pop.
  - Reaching STALL_TIMEOUT sets STALL_ERR, which clears only on RST.
  - The counter is not incremented while the FIFO is full, since backpressure is not an error.

Optional Feature:
- Macro: TLU_PACKER_ID_CHECK_EN.
- Defined:
  - On every EOF write, compare pair 3 (TRIG_ID) with the stored previous TRIG_ID + 1, modulo 2^32.
  - On mismatch, ID_ERR_CNT increments and saturates at 0xFF.
  - The first record after reset is not checked, but its ID is stored.
- Undefined: no comparison logic and no ID register; ID_ERR_CNT is tied to 0.

Test Plan:
- Upstream provides 8 words 0x0001..0x0008, OUT_READY=1 -> 4 outputs in order:
  - 0x00020001 SOF=1 EOF=0.
  - 0x00040003.
  - 0x00060005.
  - 0x00080007 EOF=1.
  - RECORD_CNT=1.
- DEPTH=16, OUT_READY=0, 8 records available:
  - Exactly 16 entries stored, then IN_READ=0.
  - Raising OUT_READY drains all 32 words in order with no duplicates or losses.
- Upstream goes empty after 3 words for 300 cycles -> STALL_ERR=1 at cycle 255 of the stall.
  - Remaining 5 words then complete the record normally.
  - STALL_ERR stays 1 until RST.
- RST asserted after 5 words -> outputs cleared.
  - Next 8 words form a record whose first pair carries SOF=1.
- TLU_PACKER_ID_CHECK_EN defined, records with TRIG_ID 0,1,2,5,6 -> ID_ERR_CNT=1.
  - Undefined: ID_ERR_CNT stays 0.
- Random OUT_READY toggling with 1000 records -> scoreboard matches every word, SOF/EOF position and RECORD_CNT=1000.
